// File: rtl/request_scheduler_if.sv
// ---------------------------------------------------------------------------
// request_scheduler_if
// Bundles the signals between the request scheduler, the button panels and
// the movement stage.
//   interior_panel [2:0] : cab buttons, bit i = floor i
//   exterior_panel [2:0] : hall buttons, bit i = floor i
//   cur_floor      [1:0] : current floor reported by the movement stage
//   served               : one-cycle pulse when the doors open at cur_floor
//   target_floor   [1:0] : floor the movement stage should travel to
//   target_valid         : target_floor is meaningful
//   dir            [1:0] : scan direction, 00 idle / 01 up / 10 down
//   pending        [2:0] : latched outstanding requests
// Modports: master = environment/testbench side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface request_scheduler_if;
    logic [2:0] interior_panel;
    logic [2:0] exterior_panel;
    logic [1:0] cur_floor;
    logic       served;
    logic [1:0] target_floor;
    logic       target_valid;
    logic [1:0] dir;
    logic [2:0] pending;

    modport master (
        output interior_panel, exterior_panel, cur_floor, served,
        input  target_floor, target_valid, dir, pending
    );

    modport slave (
        input  interior_panel, exterior_panel, cur_floor, served,
        output target_floor, target_valid, dir, pending
    );
endinterface

// File: rtl/request_scheduler.sv
// ---------------------------------------------------------------------------
// request_scheduler
// Three-floor elevator request scheduler. Latches cab/hall button presses,
// runs a SCAN-style IDLE/UP/DOWN state machine and tells the movement stage
// which floor to head for next. All outputs are registered.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : request_scheduler_if.slave (panels, cur_floor, served in;
//          target_floor, target_valid, dir, pending out)
// Parameters:
//   HOME_FLOOR   : floor targeted by idle-return
//   IDLE_TIMEOUT : idle cycles before idle-return (1..255)
// Build option:
//   REQUEST_SCHEDULER_HOME_EN : when defined, compiles in idle-return to
//   HOME_FLOOR after IDLE_TIMEOUT idle cycles away from home.
// ---------------------------------------------------------------------------
module request_scheduler #(
    parameter int HOME_FLOOR   = 0,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    request_scheduler_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] pending_reg, pending_next;
    logic [1:0] target_reg, target_next;
    logic       valid_reg, valid_next;
    logic [1:0] dir_reg, dir_next;

    logic [2:0] above_mask;
    logic [2:0] below_mask;
    logic [2:0] here_mask;
    logic       floor_legal;
    logic [1:0] lowest_above;
    logic [1:0] highest_below;

    // cur_floor = 3 is illegal: freeze scheduling and ignore served.
    assign floor_legal = (bus.cur_floor != 2'd3);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_floor
            assign here_mask[gi]  = (2'(gi) == bus.cur_floor);
            assign above_mask[gi] = pending_reg[gi] && (2'(gi) > bus.cur_floor);
            assign below_mask[gi] = pending_reg[gi] && (2'(gi) < bus.cur_floor);
        end
    endgenerate

    assign lowest_above  = above_mask[0] ? 2'd0 : (above_mask[1] ? 2'd1 : 2'd2);
    assign highest_below = below_mask[2] ? 2'd2 : (below_mask[1] ? 2'd1 : 2'd0);

    // A service pulse beats a simultaneous press on the same floor.
    always_comb begin
        pending_next = pending_reg | bus.interior_panel | bus.exterior_panel;
        if (bus.served && floor_legal) begin
            pending_next = pending_next & ~here_mask;
        end
    end

`ifdef REQUEST_SCHEDULER_HOME_EN
    localparam logic [1:0] HOME    = 2'(HOME_FLOOR);
    localparam logic [7:0] TIMEOUT = 8'(IDLE_TIMEOUT);

    logic [7:0] idle_cnt_reg, idle_cnt_next;
    logic       home_active;

    always_comb begin
        idle_cnt_next = idle_cnt_reg;
        if ((|(bus.interior_panel | bus.exterior_panel)) || (bus.cur_floor == HOME)) begin
            idle_cnt_next = 8'd0;
        end else if (floor_legal && (pending_reg == 3'b000) && (state_reg == ST_IDLE)
                     && (idle_cnt_reg < TIMEOUT)) begin
            idle_cnt_next = idle_cnt_reg + 8'd1;
        end
    end

    // Home target is published on the same edge the counter saturates.
    assign home_active = (idle_cnt_next == TIMEOUT) && floor_legal && (pending_reg == 3'b000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_reg <= 8'd0;
        end else begin
            idle_cnt_reg <= idle_cnt_next;
        end
    end
`endif

    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        valid_next  = valid_reg;
        dir_next    = dir_reg;
        if (floor_legal) begin
            valid_next = |pending_reg;
            if (pending_reg == here_mask) begin
                // Only request is where we already are: hold here until served.
                state_next  = ST_IDLE;
                target_next = bus.cur_floor;
            end else begin
                case (state_reg)
                    ST_DOWN: begin
                        if (|below_mask)      state_next = ST_DOWN;
                        else if (|above_mask) state_next = ST_UP;
                        else                  state_next = ST_IDLE;
                    end
                    default: begin
                        // IDLE and UP both prefer upward when requests lie both ways.
                        if (|above_mask)      state_next = ST_UP;
                        else if (|below_mask) state_next = ST_DOWN;
                        else                  state_next = ST_IDLE;
                    end
                endcase
                if (state_next == ST_UP)   target_next = lowest_above;
                if (state_next == ST_DOWN) target_next = highest_below;
            end
            dir_next = state_next;
`ifdef REQUEST_SCHEDULER_HOME_EN
            if (home_active) begin
                target_next = HOME;
                valid_next  = 1'b1;
                dir_next    = (HOME > bus.cur_floor) ? 2'b01 : 2'b10;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            pending_reg <= 3'b000;
            target_reg  <= 2'd0;
            valid_reg   <= 1'b0;
            dir_reg     <= 2'b00;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            target_reg  <= target_next;
            valid_reg   <= valid_next;
            dir_reg     <= dir_next;
        end
    end

    assign bus.pending      = pending_reg;
    assign bus.target_floor = target_reg;
    assign bus.target_valid = valid_reg;
    assign bus.dir          = dir_reg;

endmodule

// File: tb/tb_request_scheduler.sv
module tb_request_scheduler;

    localparam int HOME    = 0;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    request_scheduler_if bus();

    request_scheduler #(
        .HOME_FLOOR   (HOME),
        .IDLE_TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: requests as a set of floors, scan direction as an int.
    bit m_pend [3];
    int m_scan;      // 0 idle, 1 up, 2 down
    int m_dir;       // direction shown on the outputs
    int m_target;
    bit m_valid;
    int m_cnt;

    task automatic model_reset();
        for (int f = 0; f < 3; f++) m_pend[f] = 1'b0;
        m_scan = 0; m_dir = 0; m_target = 0; m_valid = 1'b0; m_cnt = 0;
    endtask

    function automatic logic [2:0] model_pending();
        logic [2:0] v;
        for (int f = 0; f < 3; f++) v[f] = m_pend[f];
        return v;
    endfunction

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input logic [2:0] ip, input logic [2:0] ep,
                              input int cf, input bit sv);
        int  near_above = -1;
        int  near_below = -1;
        bit  any = 1'b0;
        bit  go_up;
        bit  pressed = ((ip | ep) != 3'b000);
        bit  was_empty;
        bit  home_now = 1'b0;
        int  old_scan = m_scan;
        for (int f = 0; f < 3; f++) begin
            if (m_pend[f]) begin
                any = 1'b1;
                if (f > cf && near_above < 0) near_above = f;
                if (f < cf) near_below = f;
            end
        end
        was_empty = !any;
        if (pressed || cf == HOME) m_cnt = 0;
        else if (cf != 3 && was_empty && old_scan == 0 && m_cnt < TIMEOUT) m_cnt++;
`ifdef REQUEST_SCHEDULER_HOME_EN
        home_now = (m_cnt == TIMEOUT) && cf != 3 && was_empty;
`endif
        if (cf != 3) begin
            m_valid = any;
            if (any && near_above < 0 && near_below < 0) begin
                m_scan = 0; m_target = cf;
            end else if (!any) begin
                m_scan = 0;
            end else begin
                go_up = (m_scan == 2) ? (near_below < 0) : (near_above >= 0);
                if (go_up) begin m_scan = 1; m_target = near_above; end
                else       begin m_scan = 2; m_target = near_below; end
            end
            m_dir = m_scan;
            if (home_now) begin
                m_target = HOME; m_valid = 1'b1;
                m_dir = (HOME > cf) ? 1 : 2;
            end
        end
        for (int f = 0; f < 3; f++) m_pend[f] = m_pend[f] | ip[f] | ep[f];
        if (sv && cf != 3) m_pend[cf] = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pending"}, 8'(bus.pending), 8'(model_pending()));
        check({tag, ".dir"},     8'(bus.dir),     8'(m_dir));
        check({tag, ".target"},  8'(bus.target_floor), 8'(m_target));
        check({tag, ".valid"},   8'(bus.target_valid), 8'(m_valid));
    endtask

    // Called at a negative edge: drive, cross one rising edge, compare.
    task automatic cycle(input logic [2:0] ip, input logic [2:0] ep,
                         input logic [1:0] cf, input bit sv, input string tag);
        bus.interior_panel = ip;
        bus.exterior_panel = ep;
        bus.cur_floor      = cf;
        bus.served         = sv;
        model_step(ip, ep, int'(cf), sv);
        @(posedge clk);
        @(negedge clk);
        $display("cyc %s ip=%b ep=%b cf=%0d sv=%0b -> pending=%b dir=%b target=%0d valid=%0b",
                 tag, ip, ep, cf, sv, bus.pending, bus.dir, bus.target_floor, bus.target_valid);
        check_model(tag);
    endtask

    // Reset asserted between edges with panels held; outputs must clear at once.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        bus.interior_panel = 3'b111;
        bus.exterior_panel = 3'b111;
        bus.served = 1'b0;
        #1;
        model_reset();
        check({tag, ".rst_pending"}, 8'(bus.pending), 8'd0);
        check({tag, ".rst_dir"},     8'(bus.dir), 8'd0);
        check({tag, ".rst_target"},  8'(bus.target_floor), 8'd0);
        check({tag, ".rst_valid"},   8'(bus.target_valid), 8'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.interior_panel = 3'b000;
        bus.exterior_panel = 3'b000;
        $display("reset %s done", tag);
    endtask

    initial begin
        logic [2:0] rip, rep;
        logic [1:0] rcf;
        bit         rsv;
        bus.interior_panel = 3'b000;
        bus.exterior_panel = 3'b000;
        bus.cur_floor      = 2'd0;
        bus.served         = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset("init");

        // Single cab call to floor 2 from floor 0.
        cycle(3'b100, 3'b000, 2'd0, 1'b0, "r031a");
        check("r031.pending", 8'(bus.pending), 8'b100);
        cycle(3'b000, 3'b000, 2'd0, 1'b0, "r031b");
        check("r031.dir",    8'(bus.dir), 8'b01);
        check("r031.target", 8'(bus.target_floor), 8'd2);
        check("r031.valid",  8'(bus.target_valid), 8'd1);

        // Passing floor 1 with a call at floor 0 behind, then serve floor 2.
        cycle(3'b001, 3'b000, 2'd1, 1'b0, "r032a");
        cycle(3'b000, 3'b000, 2'd1, 1'b0, "r032b");
        check("r032.target_up", 8'(bus.target_floor), 8'd2);
        cycle(3'b000, 3'b000, 2'd2, 1'b1, "r032c");
        check("r032.pending", 8'(bus.pending), 8'b001);
        check("r032.dir",     8'(bus.dir), 8'b10);
        check("r032.target",  8'(bus.target_floor), 8'd0);
        cycle(3'b000, 3'b000, 2'd2, 1'b0, "r032d");

        // Press and service on the same floor in the same cycle.
        do_reset("r033");
        cycle(3'b001, 3'b000, 2'd0, 1'b1, "r033a");
        check("r033.pending", 8'(bus.pending), 8'b000);
        cycle(3'b000, 3'b000, 2'd0, 1'b0, "r033b");
        check("r033.valid", 8'(bus.target_valid), 8'd0);

        // Call at current floor plus floor above, serve current, reset mid-travel.
        do_reset("r034");
        cycle(3'b011, 3'b000, 2'd0, 1'b0, "r034a");
        cycle(3'b000, 3'b000, 2'd0, 1'b1, "r034b");
        check("r034.pending", 8'(bus.pending), 8'b010);
        check("r034.dir",     8'(bus.dir), 8'b01);
        check("r034.target",  8'(bus.target_floor), 8'd1);
        cycle(3'b000, 3'b000, 2'd0, 1'b0, "r034c");
        do_reset("r034_mid");
        cycle(3'b000, 3'b000, 2'd0, 1'b0, "r034d");

        // Illegal floor: presses latch, everything else holds.
        cycle(3'b000, 3'b100, 2'd1, 1'b0, "ill_a");
        cycle(3'b001, 3'b000, 2'd3, 1'b1, "ill_b");
        cycle(3'b000, 3'b000, 2'd3, 1'b0, "ill_c");
        check("ill.pending", 8'(bus.pending), 8'b101);

        // Idle far from home.
        do_reset("home");
        for (int i = 0; i < TIMEOUT; i++) cycle(3'b000, 3'b000, 2'd2, 1'b0, "home_wait");
`ifdef REQUEST_SCHEDULER_HOME_EN
        check("home.valid",  8'(bus.target_valid), 8'd1);
        check("home.target", 8'(bus.target_floor), 8'd0);
        check("home.dir",    8'(bus.dir), 8'b10);
        cycle(3'b000, 3'b000, 2'd1, 1'b0, "home_move");
        cycle(3'b000, 3'b000, 2'd0, 1'b0, "home_arrive");
        check("home.arrive_valid", 8'(bus.target_valid), 8'd0);
`else
        for (int i = 0; i < 4; i++) cycle(3'b000, 3'b000, 2'd2, 1'b0, "home_wait2");
        check("nohome.valid", 8'(bus.target_valid), 8'd0);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rip = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            rep = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            rcf = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rsv = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) do_reset("rand_rst");
            else cycle(rip, rep, rcf, rsv, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
